// File: rtl/hipass_serial_rx.sv
// Roadside receiver for the hipass OBU link: deserialises start / 5 data (LSB first) /
// even parity / stop frames and holds the accepted code for the toll-gate main FSM.
module hipass_serial_rx #(
    parameter int BIT_CYCLES  = 16,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       obu_rx,
    input  logic       end_output,
    output logic [4:0] hipass,
    output logic       busy,
    output logic       frame_err,
    output logic [7:0] err_cnt
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_ok(input logic [4:0] data, input logic par);
        return ~(^{data, par});
    endfunction

    logic [1:0]    r_sync;
    logic          r_rx_prev;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [4:0]    r_shift;
    logic          r_par;
    logic [4:0]    r_hipass;
    logic [HW-1:0] r_hold;
    logic          r_busy;
    logic          r_frame_err;
    logic [7:0]    r_err_cnt;

    logic   w_rx_s;
    logic   w_fall;
    logic   w_sample;
    logic   w_stop_done;
    logic   w_good;
    logic   w_bad;
    state_t w_state_nxt;

    assign w_rx_s   = r_sync[1];
    assign w_fall   = r_rx_prev & ~w_rx_s;
    // START samples at mid-bit; every later state samples one full bit period on.
    assign w_sample = (r_state == START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);
    assign w_good   = w_stop_done & w_rx_s & parity_ok(r_shift, r_par) & (r_shift != 5'd0);
    assign w_bad    = w_stop_done & ~w_good;

    // Receiver state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Receiver next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stop_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_sample) begin
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_sample && (r_bit_idx == 3'd4)) begin
                    w_state_nxt = PARITY;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                if (w_sample) begin
                    w_state_nxt = STOP;
                end else begin
                    w_state_nxt = PARITY;
                end
            end
            STOP: begin
                if (w_sample) begin
                    w_state_nxt = IDLE;
                    w_stop_done = 1'b1;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_stop_done = 1'b0;
            end
        endcase
    end

    // Line synchroniser, bit timing and frame shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 5'd0;
            r_par     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], obu_rx};
            r_rx_prev <= w_rx_s;
            if ((r_state == IDLE) || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (r_state == IDLE) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == DATA) && w_sample) begin
                r_shift   <= {w_rx_s, r_shift[4:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end else if ((r_state == PARITY) && w_sample) begin
                r_par <= w_rx_s;
            end
        end
    end

    // Code hold, error reporting and busy flag; a new good frame beats end_output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hipass    <= 5'd0;
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_busy      <= (w_state_nxt != IDLE);
            r_frame_err <= w_bad;
            if (w_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_good) begin
                r_hipass <= r_shift;
                r_hold   <= HOLD_LOAD;
            end else if (end_output) begin
                r_hipass <= 5'd0;
                r_hold   <= '0;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_ONE;
                if (r_hold == HOLD_ONE) begin
                    r_hipass <= 5'd0;
                end
            end
        end
    end

    assign hipass    = r_hipass;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_hipass_serial_rx.sv
// Bench for hipass_serial_rx: directed and random line stimulus checked every cycle
// against a sample-schedule model of the receiver, plus hand-computed literal checks.
module tb_hipass_serial_rx;
    localparam int B    = 4;
    localparam int H    = B / 2;
    localparam int HOLD = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       obu_rx;
    logic       end_output;
    logic [4:0] hipass;
    logic       busy;
    logic       frame_err;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model state: line history since reset release, plus the frame being decoded.
    bit         hist[$];
    bit         m_active;
    int         m_t0;
    bit [4:0]   m_data;
    bit         m_par;
    int         m_expire;
    logic [4:0] exp_hip;
    logic       exp_busy;
    logic       exp_err;
    logic [7:0] exp_cnt;

    hipass_serial_rx #(.BIT_CYCLES(B), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .obu_rx     (obu_rx),
        .end_output (end_output),
        .hipass     (hipass),
        .busy       (busy),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
        chk8(name, {3'b000, act}, {3'b000, exp});
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk8(name, {7'd0, act}, {7'd0, exp});
    endtask

    // Synchronised line seen in cycle j is the raw line two cycles earlier (idle-high before).
    function automatic bit rxs(input int j);
        if (j - 2 < 0) return 1'b1;
        return hist[j-2];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_active = 1'b0;
        m_t0     = 0;
        m_data   = 5'd0;
        m_par    = 1'b0;
        m_expire = -1;
        exp_hip  = 5'd0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 8'd0;
    endtask

    task automatic model_step();
        int idx;
        int k;
        bit r;
        bit rp;
        bit good;
        bit bad;
        hist.push_back(obu_rx);
        idx  = hist.size() - 1;
        r    = rxs(idx);
        rp   = rxs(idx - 1);
        good = 1'b0;
        bad  = 1'b0;
        if (!m_active) begin
            if (rp && !r) begin
                m_active = 1'b1;
                m_t0     = idx;
            end
        end else begin
            k = idx - m_t0;
            if (k == H && r) m_active = 1'b0;
            for (int i = 0; i < 5; i++) if (k == H + (i + 1) * B) m_data[i] = r;
            if (k == H + 6 * B) m_par = r;
            if (k == H + 7 * B) begin
                m_active = 1'b0;
                if (r && ((^m_data) == m_par) && (m_data != 5'd0)) good = 1'b1;
                else bad = 1'b1;
            end
        end
        exp_busy = m_active;
        exp_err  = bad;
        if (bad && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        if (good) begin
            exp_hip  = m_data;
            m_expire = idx + HOLD;
        end else if (end_output) begin
            exp_hip  = 5'd0;
            m_expire = -1;
        end else if (idx == m_expire) begin
            exp_hip  = 5'd0;
            m_expire = -1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk5("cyc_hipass", hipass, exp_hip);
                chk1("cyc_busy", busy, exp_busy);
                chk1("cyc_frame_err", frame_err, exp_err);
                chk8("cyc_err_cnt", err_cnt, exp_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [4:0] d, input logic p, input logic s);
        logic [7:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 8; i++) begin
            obu_rx = bits[i];
            repeat (B) tick();
        end
        obu_rx = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        obu_rx     = 1'b1;
        end_output = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            obu_rx = ~obu_rx;
            if (i == 2) chk_en = 1'b1;
        end
        chk5("rst_hipass", hipass, 5'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        chk8("rst_err_cnt", err_cnt, 8'd0);
        obu_rx = 1'b1;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        chk5("rel_hipass", hipass, 5'd0);
        chk1("rel_busy", busy, 1'b0);

        send_frame(5'b01111, 1'b0, 1'b1);
        chk1("good_busy_at_stop", busy, 1'b1);
        tick();
        chk5("good_hipass", hipass, 5'b01111);
        chk1("good_busy_fall", busy, 1'b0);
        repeat (19) tick();
        chk5("hold_last", hipass, 5'b01111);
        tick();
        chk5("hold_expire", hipass, 5'd0);
        repeat (3) tick();

        send_frame(5'b00001, 1'b0, 1'b1);
        tick();
        chk1("par_frame_err", frame_err, 1'b1);
        chk8("par_err_cnt", err_cnt, 8'd1);
        chk5("par_hipass", hipass, 5'd0);
        tick();
        chk1("par_err_pulse_end", frame_err, 1'b0);
        repeat (3) tick();

        send_frame(5'b00110, 1'b0, 1'b0);
        tick();
        chk8("stop_err_cnt", err_cnt, 8'd2);
        chk5("stop_hipass", hipass, 5'd0);
        repeat (3) tick();

        obu_rx = 1'b0;
        tick();
        obu_rx = 1'b1;
        repeat (2) tick();
        chk1("glitch_busy_rise", busy, 1'b1);
        repeat (2) tick();
        chk1("glitch_busy_fall", busy, 1'b0);
        repeat (6) tick();
        chk8("glitch_err_cnt", err_cnt, 8'd2);
        chk5("glitch_hipass", hipass, 5'd0);

        send_frame(5'b10100, 1'b0, 1'b1);
        tick();
        chk5("eo_hipass", hipass, 5'b10100);
        repeat (4) tick();
        end_output = 1'b1;
        tick();
        end_output = 1'b0;
        chk5("eo_clear", hipass, 5'd0);
        repeat (5) tick();
        chk5("eo_stays_clear", hipass, 5'd0);

        send_frame(5'b00011, 1'b0, 1'b1);
        end_output = 1'b1;
        tick();
        end_output = 1'b0;
        chk5("load_beats_eo", hipass, 5'b00011);
        repeat (3) tick();

        obu_rx = 1'b0;
        repeat (3 * B) tick();
        repeat (2) tick();
        chk1("mid_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk5("mid_rst_hipass", hipass, 5'd0);
        chk8("mid_rst_err_cnt", err_cnt, 8'd0);
        repeat (3) tick();
        obu_rx = 1'b1;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        send_frame(5'b11000, 1'b0, 1'b1);
        tick();
        chk5("after_rst_hipass", hipass, 5'b11000);
        chk8("after_rst_err_cnt", err_cnt, 8'd0);
        repeat (3) tick();

        repeat (40) begin
            if ($urandom_range(0, 2) == 0) begin
                end_output = 1'b1;
                tick();
                end_output = 1'b0;
            end
            send_frame(5'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
            repeat ($urandom_range(2, 25)) tick();
        end

        repeat (1500) begin
            obu_rx     = ($urandom_range(0, 5) != 0);
            end_output = ($urandom_range(0, 40) == 0);
            tick();
        end
        obu_rx     = 1'b1;
        end_output = 1'b0;
        repeat (40) tick();

        repeat (256) begin
            send_frame(5'b00001, 1'b0, 1'b1);
            repeat (2) tick();
        end
        chk8("sat_err_cnt", err_cnt, 8'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hipass_serial_rx.md
Name: hipass_serial_rx

Overview:
- Roadside receiver for the hipass on-board-unit (OBU) link.
- Deserialises the OBU's UART-style frame, checks parity and the stop bit, and presents the 5-bit hipass code to the toll-gate main FSM on hipass[4:0].
- Holds the code until the main FSM pulses end_output, or until a hold timeout expires.
- Produces the hipass code that the main FSM consumes.

Parameters:
- BIT_CYCLES, 16, clocks per serial bit; even, >= 4.
- HOLD_CYCLES, 1000, clocks that hipass is held after a good frame when end_output does not arrive.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  asynchronous, active-low reset.
- obu_rx  input  1  serial line from the OBU; idles high; asynchronous to clk.
- end_output  input  1  from the main FSM; high for >= 1 cycle ends the transaction.
- hipass  output  5  received code; 0 means no card.
- busy  output  1  high while a frame is being received (states START..STOP).
- frame_err  output  1  one-cycle pulse on a rejected frame.
- err_cnt  output  8  saturating count of rejected frames.

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-low.
- Reset (rst=0) forces all outputs and internal state immediately:
  - hipass=0, busy=0, frame_err=0, err_cnt=0.
  - FSM=IDLE; synchroniser flops=1.
- Input synchroniser: obu_rx passes through a 2-FF synchroniser; rx_s denotes the synchronised line.
- Frame format: start bit (0), 5 data bits LSB first, even parity bit, stop bit (1).
  - Even parity: XOR of the 5 data bits and the parity bit must be 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A 1->0 transition on rx_s at cycle t0 enters START and clears the bit-cycle counter.
- START:
  - At t0+BIT_CYCLES/2, rx_s is sampled.
  - If rx_s=1: glitch; return to IDLE with no error and no err_cnt change.
  - Otherwise: go to DATA.
- DATA:
  - Bit i (i=0..4) is sampled at t0+BIT_CYCLES/2+(i+1)*BIT_CYCLES and shifted in LSB first.
  - After bit 4, go to PARITY.
- PARITY: sample at t0+BIT_CYCLES/2+6*BIT_CYCLES.
- STOP: sample at t0+BIT_CYCLES/2+7*BIT_CYCLES, then always return to IDLE.
  - Frame is good only if: stop=1, parity OK, and data != 0 (code 0 is reserved).
- Good frame:
  - The cycle after the stop sample: hipass <= data, hold counter <= HOLD_CYCLES.
- Rejected frame:
  - The cycle after the stop sample: frame_err=1 for exactly one cycle.
  - err_cnt increments, saturating at 255.
  - hipass is unchanged.
- A falling edge is only recognised in IDLE. Line activity during START..STOP other than the scheduled samples is ignored.
- Hold counter:
  - Decrements each cycle while nonzero.
  - On the transition to 0, hipass <= 0.
- end_output=1: hipass <= 0 and hold counter <= 0 on the next edge.
- Simultaneous events: a good-frame load and end_output in the same cycle resolve as load wins (new car). The hold counter is reloaded.
- The receiver FSM runs independently of the hold logic. A new good frame during hold overwrites hipass and restarts the hold.
- Reset mid-frame: partial data is discarded, the FSM returns to IDLE, and no frame_err is raised.
- busy=1 from the cycle START is entered through the cycle of the stop sample.

Test Plan (BIT_CYCLES=4, HOLD_CYCLES=20):
- Reset: hold rst=0 with obu_rx toggling. Required: hipass=0, busy=0, frame_err=0, err_cnt=0 throughout. Release rst: outputs unchanged while the line idles high.
- Good frame: data 5'b01111, parity 0, stop 1. Required: hipass=5'b01111 one cycle after the stop sample; busy falls. hipass returns to 0 exactly 20 cycles later with no end_output.
- Parity error: data 5'b00001, parity 0. Required: hipass stays 0, one-cycle frame_err, err_cnt=1. Stop bit 0 on an otherwise valid frame: err_cnt=2.
- Glitch: obu_rx low for 1 clock, then high. Required: busy rises, then falls by mid-start. No frame_err, err_cnt unchanged, hipass unchanged.
- end_output: good frame 5'b10100 (parity 0), then end_output=1 for 1 cycle, 5 cycles into the hold. Required: hipass=0 next cycle and stays 0. Also end_output in the same cycle as a load of 5'b00011: hipass=5'b00011.
- Reset mid-frame: drop rst during DATA bit 2, then release and send frame 5'b11000 (parity 0). Required: no frame_err from the aborted frame, and hipass=5'b11000. 256 bad frames: err_cnt saturates at 255.
